// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble: one right shift
// of {digits, accumulator} plus per-digit correction per clock, WIDTH clocks per conversion.
module bcd2bin_seq #(
  parameter int WIDTH  = 18,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIGITS*4-1:0]   bcd,
  output logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  ovf
);

  localparam int DW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    d_q, d_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;

  logic [DW-1:0]    sh_d, corr_d;
  logic [WIDTH-1:0] sh_a;
  logic             bad_digit;

  // Shift then correct: every post-shift digit >= 8 gets 3 subtracted, all in parallel.
  always_comb begin
    {sh_d, sh_a} = {d_q, a_q} >> 1;
    corr_d       = sh_d;
    for (int j = 0; j < DIGITS; j++) begin
      if (sh_d[4*j +: 4] >= 4'd8) corr_d[4*j +: 4] = sh_d[4*j +: 4] - 4'd3;
    end
    bad_digit = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if (bcd[4*j +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    done_d  = 1'b0;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_digit) begin
            bin_d  = '0;
            err_d  = 1'b1;
            ovf_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            d_d     = bcd;
            a_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        d_d   = corr_d;
        a_d   = sh_a;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          bin_d   = sh_a;
          ovf_d   = |corr_d;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bin  = bin_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign err  = err_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: default (WIDTH=18) and WIDTH=8 instances,
// directed and random operands checked against an arithmetic decimal model.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start8;
  logic [15:0] bcd, bcd8;
  logic [17:0] bin;
  logic [7:0]  bin8;
  logic        busy, done, err, ovf;
  logic        busy8, done8, err8, ovf8;

  int errors = 0;
  int checks = 0;

  bcd2bin_seq u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd(bcd), .bin(bin),
    .busy(busy), .done(done), .err(err), .ovf(ovf)
  );

  bcd2bin_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bcd(bcd8), .bin(bin8),
    .busy(busy8), .done(done8), .err(err8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal value of the digits, then reduced to w bits; any digit > 9 flags an error.
  function automatic void model(input logic [15:0] v, input int w,
                                output logic [31:0] b, output bit e, output bit o);
    int val;
    val = 0;
    e   = 1'b0;
    for (int j = 3; j >= 0; j--) begin
      int dg;
      dg = int'(v[4*j +: 4]);
      if (dg > 9) e = 1'b1;
      val = val * 10 + dg;
    end
    if (e) begin
      b = '0;
      o = 1'b0;
    end else begin
      b = 32'(val % (1 << w));
      o = (val >= (1 << w));
    end
  endfunction

  function automatic logic o_busy(input int sel); return sel == 0 ? busy : busy8; endfunction
  function automatic logic o_done(input int sel); return sel == 0 ? done : done8; endfunction
  function automatic logic o_err (input int sel); return sel == 0 ? err  : err8;  endfunction
  function automatic logic o_ovf (input int sel); return sel == 0 ? ovf  : ovf8;  endfunction
  function automatic logic [31:0] o_bin(input int sel); return sel == 0 ? 32'(bin) : 32'(bin8); endfunction

  task automatic drive(input int sel, input logic s, input logic [15:0] v);
    if (sel == 0) begin start = s; bcd = v; end
    else begin start8 = s; bcd8 = v; end
  endtask

  // One full conversion: pulse start, scramble bcd after acceptance, time busy, check results.
  task automatic run(input int sel, input logic [15:0] v, input string tag);
    logic [31:0] eb;
    bit ee, eo, bad_done;
    int n, w;
    w = (sel == 0) ? 18 : 8;
    model(v, w, eb, ee, eo);
    @(negedge clk);
    drive(sel, 1'b1, v);
    @(negedge clk);
    drive(sel, 1'b0, 16'($urandom));
    n = 0;
    bad_done = 1'b0;
    while (o_busy(sel) === 1'b1 && n < 100) begin
      if (o_done(sel)) bad_done = 1'b1;
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, n, ee ? 0 : w);
    check({tag, " done_during_busy"}, 32'(bad_done), 0);
    check({tag, " done"}, 32'(o_done(sel)), 1);
    check({tag, " bin"}, o_bin(sel), eb);
    check({tag, " err"}, 32'(o_err(sel)), 32'(ee));
    check({tag, " ovf"}, 32'(o_ovf(sel)), 32'(eo));
    @(negedge clk);
    check({tag, " done_pulse_end"}, 32'(o_done(sel)), 0);
    check({tag, " err_held"}, 32'(o_err(sel)), 32'(ee));
  endtask

  initial begin
    int n;
    bit seen;
    logic [15:0] v;
    rst_n = 1'b0;
    start = 1'b0; start8 = 1'b0;
    bcd = '0; bcd8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {busy, done, err, ovf, 14'd0, bin}, 0);
    check("reset outputs w8", {busy8, done8, err8, ovf8, 20'd0, bin8}, 0);
    rst_n = 1'b1;

    run(0, 16'h1234, "d1234");
    run(0, 16'h9999, "d9999");
    run(0, 16'h0000, "d0000");
    run(0, 16'h12A4, "bad12A4");
    run(1, 16'h0256, "w8_256");
    run(1, 16'h0255, "w8_255");
    run(1, 16'h9999, "w8_9999");

    // start re-pulsed mid-conversion must be ignored
    @(negedge clk); start = 1'b1; bcd = 16'h0777;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; bcd = 16'h0001;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("restart done", 32'(done), 1);
    check("restart bin", 32'(bin), 32'd777);
    @(negedge clk);
    check("restart no second run", 32'(busy), 0);

    // start held through done: second conversion starts with no bubble
    @(negedge clk); start = 1'b1; bcd = 16'h0123;
    @(negedge clk); bcd = 16'h0456;
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("b2b first latency", n, 18);
    check("b2b first done", 32'(done), 1);
    check("b2b first bin", 32'(bin), 32'd123);
    @(negedge clk); start = 1'b0;
    check("b2b second busy", 32'(busy), 1);
    check("b2b second done low", 32'(done), 0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
    check("b2b second latency", n, 18);
    check("b2b second bin", 32'(bin), 32'd456);
    check("b2b second ovf", 32'(ovf), 0);

    // asynchronous reset in the middle of a conversion
    @(negedge clk); start = 1'b1; bcd = 16'h1234;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst pre busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check("rst async outputs", {busy, done, err, ovf, 14'd0, bin}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rst no done", 32'(seen), 0);
    run(0, 16'h0042, "after_rst42");

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) v[4*j +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
      run(i % 2, v, $sformatf("rand%0d_%h", i, v));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
